// File: rtl/mips_cpu_mult_div_if.sv
// Request/response bundle between the core and the multiply/divide unit.
// The core drives the request side; the unit drives status, read data and HI/LO.
interface mips_cpu_mult_div_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  busy;
    logic                  stall;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  read_data, busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output read_data, busy, stall, done, hi, lo
    );
endinterface

// File: rtl/mips_cpu_mult_div.sv
// Iterative MIPS multiply/divide unit owning HI/LO: one shift-add or restoring
// shift-subtract step per cycle on operand magnitudes, sign fix-up in a final cycle.
module mips_cpu_mult_div #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    mips_cpu_mult_div_if.slave   bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W:0]      acc_hi_q, acc_hi_d;
    logic [W-1:0]    acc_lo_q, acc_lo_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [W-1:0]    a_raw_q, a_raw_d;
    logic            is_mul_q, is_mul_d;
    logic            neg_q_q, neg_q_d;
    logic            neg_r_q, neg_r_d;
    logic            bzero_q, bzero_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            sgn_a_s, sgn_b_s;
    logic [W-1:0]    mag_a_s, mag_b_s;
    logic [W:0]      mul_sum_s;
    logic [W:0]      div_shift_s;
    logic [W:0]      div_diff_s;
    logic [2*W-1:0]  prod_s;

    function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic n);
        return n ? (~v + W'(1)) : v;
    endfunction

    function automatic logic [2*W-1:0] cond_neg2(input logic [2*W-1:0] v, input logic n);
        return n ? (~v + (2*W)'(1)) : v;
    endfunction

    // Next-state, datapath step and HI/LO update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        opnd_d      = opnd_q;
        a_raw_d     = a_raw_q;
        is_mul_d    = is_mul_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        bzero_d     = bzero_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;
        sgn_a_s     = bus.op[1] & bus.a[W-1];
        sgn_b_s     = bus.op[1] & bus.b[W-1];
        mag_a_s     = cond_neg(bus.a, sgn_a_s);
        mag_b_s     = cond_neg(bus.b, sgn_b_s);
        mul_sum_s   = '0;
        div_shift_s = '0;
        div_diff_s  = '0;
        prod_s      = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.op[2]) begin
                    // Multiply keeps the multiplier in the low half; divide keeps the dividend there
                    is_mul_d = bus.op[0];
                    acc_hi_d = '0;
                    acc_lo_d = bus.op[0] ? mag_b_s : mag_a_s;
                    opnd_d   = bus.op[0] ? mag_a_s : mag_b_s;
                    neg_q_d  = sgn_a_s ^ sgn_b_s;
                    neg_r_d  = sgn_a_s;
                    a_raw_d  = bus.a;
                    bzero_d  = (bus.b == '0);
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end else if (bus.start && (bus.op[2:1] == 2'b10)) begin
                    if (bus.op[0]) begin
                        lo_d = bus.a;
                    end else begin
                        hi_d = bus.a;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (is_mul_q) begin
                    mul_sum_s = {1'b0, acc_hi_q[W-1:0]} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
                    acc_hi_d  = {1'b0, mul_sum_s[W:1]};
                    acc_lo_d  = {mul_sum_s[0], acc_lo_q[W-1:1]};
                end else begin
                    // Remainder stays below the divisor, so bit W of the difference is the borrow
                    div_shift_s = {acc_hi_q[W-1:0], acc_lo_q[W-1]};
                    div_diff_s  = div_shift_s - {1'b0, opnd_q};
                    if (!div_diff_s[W]) begin
                        acc_hi_d = div_diff_s;
                        acc_lo_d = {acc_lo_q[W-2:0], 1'b1};
                    end else begin
                        acc_hi_d = div_shift_s;
                        acc_lo_d = {acc_lo_q[W-2:0], 1'b0};
                    end
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FIN: begin
                if (is_mul_q) begin
                    prod_s     = cond_neg2({acc_hi_q[W-1:0], acc_lo_q}, neg_q_q);
                    {hi_d, lo_d} = prod_s;
                end else if (bzero_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    hi_d = cond_neg(acc_hi_q[W-1:0], neg_r_q);
                    lo_d = cond_neg(acc_lo_q, neg_q_q);
                end
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            is_mul_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            bzero_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            a_raw_q  <= a_raw_d;
            is_mul_q <= is_mul_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            bzero_q  <= bzero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Register reads and stall decode
    always_comb begin
        case (bus.op)
            3'b110:  bus.read_data = hi_q;
            3'b111:  bus.read_data = lo_q;
            default: bus.read_data = '0;
        endcase
        bus.stall = bus.start & busy_q;
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mips_cpu_mult_div.sv
// Directed self-checking bench for mips_cpu_mult_div with hand-computed results.
module tb_mips_cpu_mult_div;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mips_cpu_mult_div_if #(.DATA_WIDTH(32)) bus ();

    mips_cpu_mult_div #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request for a single cycle, then scramble the inputs
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h0BAD_F00D;
    endtask

    // Observe a fixed window, counting busy cycles, done pulses and overlap
    task automatic watch(output int nbusy, output int ndone, output int nboth);
        nbusy = 0;
        ndone = 0;
        nboth = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy) nbusy++;
            if (bus.done) ndone++;
            if (bus.busy && bus.done) nboth++;
            @(negedge clk);
        end
    endtask

    task automatic run_case(input string tag, input logic [2:0] o, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
        int nb, nd, nx;
        issue(o, x, y);
        watch(nb, nd, nx);
        check_eq({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, ehi});
        check_eq({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, elo});
        check_eq({tag, "_done"}, 64'(nd), 64'd1);
    endtask

    initial begin
        int nb, nd, nx;
        bit seen;
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_hi", {32'd0, bus.hi}, 64'd0);
        check_eq("rst_lo", {32'd0, bus.lo}, 64'd0);
        check_eq("rst_busy", {63'd0, bus.busy}, 64'd0);
        check_eq("rst_done", {63'd0, bus.done}, 64'd0);

        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        watch(nb, nd, nx);
        check_eq("multu_busy_cycles", 64'(nb), 64'd33);
        check_eq("multu_done_cnt", 64'(nd), 64'd1);
        check_eq("multu_done_busy_overlap", 64'(nx), 64'd0);
        check_eq("multu_hi", {32'd0, bus.hi}, 64'hFFFF_FFFE);
        check_eq("multu_lo", {32'd0, bus.lo}, 64'h0000_0001);

        run_case("mult_neg3x7", 3'b011, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_case("mult_min_sq", 3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_case("mult_m1x1", 3'b011, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_case("div_m7d2", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_case("div_7dm2", 3'b010, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_case("divu_by0", 3'b000, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
        run_case("div_by0_neg", 3'b010, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run_case("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_case("divu_big", 3'b000, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);

        issue(3'b100, 32'h1234_5678, 32'd0);
        bus.op = 3'b110;
        #1 check_eq("mfhi", {32'd0, bus.read_data}, 64'h1234_5678);
        check_eq("mthi_no_busy", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        issue(3'b101, 32'hCAFE_BABE, 32'd0);
        bus.op = 3'b111;
        #1 check_eq("mflo", {32'd0, bus.read_data}, 64'hCAFE_BABE);
        bus.op = 3'b011;
        #1 check_eq("rd_nonmf_zero", {32'd0, bus.read_data}, 64'd0);
        @(negedge clk);

        // Competing MULT request while DIVU is running must be stalled and dropped
        issue(3'b000, 32'd1000, 32'd7);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b011;
        bus.a     = 32'd5;
        bus.b     = 32'd5;
        #1 check_eq("stall_mult", {63'd0, bus.stall}, 64'd1);
        @(negedge clk);
        bus.op = 3'b110;
        #1 check_eq("stall_mfhi", {63'd0, bus.stall}, 64'd1);
        check_eq("mfhi_while_busy", {32'd0, bus.read_data}, 64'h1234_5678);
        @(negedge clk);
        bus.start = 1'b0;
        #1 check_eq("no_stall_idle_req", {63'd0, bus.stall}, 64'd0);
        watch(nb, nd, nx);
        check_eq("stall_done_cnt", 64'(nd), 64'd1);
        check_eq("stall_hi", {32'd0, bus.hi}, 64'd6);
        check_eq("stall_lo", {32'd0, bus.lo}, 64'd142);

        // Reset in the middle of a MULT aborts it without touching HI/LO afterwards
        issue(3'b011, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_hi", {32'd0, bus.hi}, 64'd0);
        check_eq("abort_lo", {32'd0, bus.lo}, 64'd0);
        check_eq("abort_busy", {63'd0, bus.busy}, 64'd0);
        watch(nb, nd, nx);
        check_eq("abort_no_done", 64'(nd), 64'd0);
        run_case("after_abort", 3'b001, 32'd6, 32'd7, 32'd0, 32'd42);

        // MTLO in the done cycle lands on top of the fresh result
        issue(3'b001, 32'd2, 32'd3);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("done_seen", {63'd0, seen}, 64'd1);
        bus.start = 1'b1;
        bus.op    = 3'b101;
        bus.a     = 32'h0000_0055;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("mt_on_done_lo", {32'd0, bus.lo}, 64'h55);
        check_eq("mt_on_done_hi", {32'd0, bus.hi}, 64'd0);
        check_eq("mt_on_done_busy", {63'd0, bus.busy}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
